// File: rtl/svga_raster_timing_gen.sv
// Parametrised raster timing: sync/blank/border plus text-cell and graphics address counters.
// Define SVGA_RASTER_IRQ_EN to add the raster-line interrupt (irq_line, irq_ack, raster_irq).
module svga_raster_timing_gen #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int HS_POL       = 1,
    parameter int VS_POL       = 1,
    parameter int BORDER_X     = 64,
    parameter int BORDER_Y     = 48,
    parameter int DECODE_DELAY = 7
) (
    input  logic        pixel_clock,
    input  logic        reset,
    input  logic [3:0]  cell_w_m1,
    input  logic [4:0]  cell_h_m1,
    input  logic [1:0]  pix_rep_m1,
    input  logic [1:0]  line_rep_m1,
`ifdef SVGA_RASTER_IRQ_EN
    input  logic [9:0]  irq_line,
    input  logic        irq_ack,
    output logic        raster_irq,
`endif
    output logic        h_synch,
    output logic        v_synch,
    output logic        blank,
    output logic [10:0] pixel_count,
    output logic [9:0]  line_count,
    output logic        show_border,
    output logic        frame_start,
    output logic [3:0]  subchar_pixel,
    output logic [4:0]  subchar_line,
    output logic [6:0]  char_column,
    output logic [6:0]  char_line,
    output logic [8:0]  graph_x,
    output logic [8:0]  graph_y
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [10:0] BX_FIRST = 11'(BORDER_X);
    localparam logic [10:0] BX_LAST  = 11'(H_ACTIVE - BORDER_X - 1);
    localparam logic [9:0]  BY_FIRST = 10'(BORDER_Y);
    localparam logic [9:0]  BY_LAST  = 10'(V_ACTIVE - BORDER_Y - 1);
    localparam logic [10:0] FW_FIRST = 11'(BORDER_X - DECODE_DELAY);
    localparam logic [10:0] FW_LAST  = 11'(H_ACTIVE - BORDER_X - DECODE_DELAY - 1);
    localparam logic        HS_ON    = (HS_POL != 0);
    localparam logic        VS_ON    = (VS_POL != 0);

    logic [10:0] pc_q, pc_d;
    logic [9:0]  lc_q, lc_d;
    logic        hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
    logic        border_q, border_d, fs_q, fs_d;
    logic [3:0]  cw_q, cw_d;
    logic [4:0]  ch_q, ch_d;
    logic [1:0]  pr_q, pr_d, lr_q, lr_d;
    logic [3:0]  sub_px_q, sub_px_d;
    logic [6:0]  col_q, col_d;
    logic [8:0]  gx_q, gx_d;
    logic [1:0]  prep_q, prep_d;
    logic [4:0]  sub_ln_q, sub_ln_d;
    logic [6:0]  row_q, row_d;
    logic [8:0]  gy_q, gy_d;
    logic [1:0]  lrep_q, lrep_d;
    logic        h_wrap, fetch_win, line_win, h_vis, l_vis;

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            pc_q     <= '0;
            lc_q     <= '0;
            hs_q     <= ~HS_ON;
            vs_q     <= ~VS_ON;
            blank_q  <= 1'b0;
            border_q <= 1'b1;
            fs_q     <= 1'b0;
            cw_q     <= '0;
            ch_q     <= '0;
            pr_q     <= '0;
            lr_q     <= '0;
            sub_px_q <= '0;
            col_q    <= '0;
            gx_q     <= '0;
            prep_q   <= '0;
            sub_ln_q <= '0;
            row_q    <= '0;
            gy_q     <= '0;
            lrep_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            lc_q     <= lc_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            blank_q  <= blank_d;
            border_q <= border_d;
            fs_q     <= fs_d;
            cw_q     <= cw_d;
            ch_q     <= ch_d;
            pr_q     <= pr_d;
            lr_q     <= lr_d;
            sub_px_q <= sub_px_d;
            col_q    <= col_d;
            gx_q     <= gx_d;
            prep_q   <= prep_d;
            sub_ln_q <= sub_ln_d;
            row_q    <= row_d;
            gy_q     <= gy_d;
            lrep_q   <= lrep_d;
        end
    end

    // Flags are computed from the next position so they line up with the counters.
    always_comb begin
        h_wrap = (pc_q == H_LAST);
        pc_d   = h_wrap ? '0 : pc_q + 11'd1;
        lc_d   = lc_q;
        if (h_wrap) lc_d = (lc_q == V_LAST) ? '0 : lc_q + 10'd1;

        hs_d     = (pc_d >= HS_FIRST && pc_d <= HS_LAST) ? HS_ON : ~HS_ON;
        vs_d     = (lc_d >= VS_FIRST && lc_d <= VS_LAST) ? VS_ON : ~VS_ON;
        blank_d  = (pc_d >= H_ACT) || (lc_d >= V_ACT);
        h_vis    = (pc_d >= BX_FIRST) && (pc_d <= BX_LAST);
        l_vis    = (lc_d >= BY_FIRST) && (lc_d <= BY_LAST);
        border_d = ~(h_vis && l_vis);
        fs_d     = (pc_d == '0) && (lc_d == '0);

        cw_d = cw_q;
        ch_d = ch_q;
        pr_d = pr_q;
        lr_d = lr_q;
        if (fs_q) begin
            cw_d = cell_w_m1;
            ch_d = cell_h_m1;
            pr_d = pix_rep_m1;
            lr_d = line_rep_m1;
        end

        fetch_win = (pc_q >= FW_FIRST) && (pc_q <= FW_LAST);
        line_win  = (lc_q >= BY_FIRST) && (lc_q <= BY_LAST);

        sub_px_d = sub_px_q;
        col_d    = col_q;
        gx_d     = gx_q;
        prep_d   = prep_q;
        if (h_wrap) begin
            sub_px_d = '0;
            col_d    = '0;
            gx_d     = '0;
            prep_d   = '0;
        end else if (fetch_win) begin
            if (sub_px_q == cw_q) begin
                sub_px_d = '0;
                col_d    = col_q + 7'd1;
            end else begin
                sub_px_d = sub_px_q + 4'd1;
            end
            if (prep_q == pr_q) begin
                prep_d = '0;
                gx_d   = gx_q + 9'd1;
            end else begin
                prep_d = prep_q + 2'd1;
            end
        end

        sub_ln_d = sub_ln_q;
        row_d    = row_q;
        gy_d     = gy_q;
        lrep_d   = lrep_q;
        if (fs_d) begin
            sub_ln_d = '0;
            row_d    = '0;
            gy_d     = '0;
            lrep_d   = '0;
        end else if (h_wrap && line_win) begin
            if (sub_ln_q == ch_q) begin
                sub_ln_d = '0;
                row_d    = row_q + 7'd1;
            end else begin
                sub_ln_d = sub_ln_q + 5'd1;
            end
            if (lrep_q == lr_q) begin
                lrep_d = '0;
                gy_d   = gy_q + 9'd1;
            end else begin
                lrep_d = lrep_q + 2'd1;
            end
        end
    end

`ifdef SVGA_RASTER_IRQ_EN
    logic irq_q, irq_d, irq_set_now, irq_set_next;

    // An ack landing on the set cycle itself is ignored so the set wins.
    always_comb begin
        irq_set_now  = (pc_q == '0) && (lc_q == irq_line);
        irq_set_next = (pc_d == '0) && (lc_d == irq_line);
        irq_d        = irq_set_next || (irq_q && !(irq_ack && !irq_set_now));
    end

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end

    assign raster_irq = irq_q;
`endif

    assign h_synch       = hs_q;
    assign v_synch       = vs_q;
    assign blank         = blank_q;
    assign pixel_count   = pc_q;
    assign line_count    = lc_q;
    assign show_border   = border_q;
    assign frame_start   = fs_q;
    assign subchar_pixel = sub_px_q;
    assign subchar_line  = sub_ln_q;
    assign char_column   = col_q;
    assign char_line     = row_q;
    assign graph_x       = gx_q;
    assign graph_y       = gy_q;

endmodule

// File: tb/tb_svga_raster_timing_gen.sv
// Scoreboard bench for svga_raster_timing_gen: random config/reset stimulus, arithmetic reference model.
module tb_svga_raster_timing_gen;

    localparam int H_ACTIVE = 64, H_FP = 4, H_SYNC = 8, H_BP = 6;
    localparam int V_ACTIVE = 48, V_FP = 3, V_SYNC = 2, V_BP = 4;
    localparam int HS_POL = 1, VS_POL = 0;
    localparam int BORDER_X = 8, BORDER_Y = 6, DECODE_DELAY = 3;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME   = H_TOTAL * V_TOTAL;
    localparam int N_CYC   = 10 * FRAME;
    localparam int F_LO    = BORDER_X - DECODE_DELAY;
    localparam int F_HI    = H_ACTIVE - BORDER_X - DECODE_DELAY - 1;
    localparam int LW_HI   = V_ACTIVE - BORDER_Y - 1;

    typedef struct packed {
        logic        hs, vs, blank, border, fs;
        logic [10:0] pc;
        logic [9:0]  lc;
        logic [3:0]  sp;
        logic [4:0]  sl;
        logic [6:0]  cc, cl;
        logic [8:0]  gx, gy;
        logic        irq;
    } exp_t;

    logic        clk = 1'b1;
    logic        rst = 1'b1;
    logic [3:0]  cell_w_m1 = '0;
    logic [4:0]  cell_h_m1 = '0;
    logic [1:0]  pix_rep_m1 = '0, line_rep_m1 = '0;
    logic        h_synch, v_synch, blank, show_border, frame_start;
    logic [10:0] pixel_count;
    logic [9:0]  line_count;
    logic [3:0]  subchar_pixel;
    logic [4:0]  subchar_line;
    logic [6:0]  char_column, char_line;
    logic [8:0]  graph_x, graph_y;
    logic        raster_irq;
`ifdef SVGA_RASTER_IRQ_EN
    logic [9:0]  irq_line = 10'd20;
    logic        irq_ack = 1'b0;
`else
    assign raster_irq = 1'b0;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    svga_raster_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .BORDER_X(BORDER_X),
        .BORDER_Y(BORDER_Y), .DECODE_DELAY(DECODE_DELAY)
    ) dut (
        .pixel_clock(clk),
        .reset(rst),
        .cell_w_m1(cell_w_m1),
        .cell_h_m1(cell_h_m1),
        .pix_rep_m1(pix_rep_m1),
        .line_rep_m1(line_rep_m1),
`ifdef SVGA_RASTER_IRQ_EN
        .irq_line(irq_line),
        .irq_ack(irq_ack),
        .raster_irq(raster_irq),
`endif
        .h_synch(h_synch),
        .v_synch(v_synch),
        .blank(blank),
        .pixel_count(pixel_count),
        .line_count(line_count),
        .show_border(show_border),
        .frame_start(frame_start),
        .subchar_pixel(subchar_pixel),
        .subchar_line(subchar_line),
        .char_column(char_column),
        .char_line(char_line),
        .graph_x(graph_x),
        .graph_y(graph_y)
    );

    // Expected outputs at raster position (p,l): counters are the number of
    // window steps already taken, divided down by the cell/repeat sizes.
    function automatic exp_t model_at(int p, int l, int cw, int ch, int pr, int lr, bit fs);
        exp_t e;
        int   n, m;
        n = (p <= F_LO) ? 0 : (((p < F_HI + 1) ? p : F_HI + 1) - F_LO);
        m = (l <= BORDER_Y) ? 0 : (((l < LW_HI + 1) ? l : LW_HI + 1) - BORDER_Y);
        e.hs     = ((p >= H_ACTIVE + H_FP) && (p < H_ACTIVE + H_FP + H_SYNC)) == (HS_POL != 0);
        e.vs     = ((l >= V_ACTIVE + V_FP) && (l < V_ACTIVE + V_FP + V_SYNC)) == (VS_POL != 0);
        e.blank  = (p >= H_ACTIVE) || (l >= V_ACTIVE);
        e.border = !((p >= BORDER_X) && (p <= H_ACTIVE - BORDER_X - 1) &&
                     (l >= BORDER_Y) && (l <= LW_HI));
        e.fs     = fs;
        e.pc     = 11'(p);
        e.lc     = 10'(l);
        e.sp     = 4'(n % (cw + 1));
        e.cc     = 7'(n / (cw + 1));
        e.gx     = 9'(n / (pr + 1));
        e.sl     = 5'(m % (ch + 1));
        e.cl     = 7'(m / (ch + 1));
        e.gy     = 9'(m / (lr + 1));
        e.irq    = 1'b0;
        return e;
    endfunction

    function automatic bit reset_at(int cyc);
        return (cyc < 4) ||
               (cyc >= 3 * FRAME + 30 * H_TOTAL + 40 && cyc < 3 * FRAME + 30 * H_TOTAL + 43) ||
               (cyc == 6 * FRAME - 2) ||
               (cyc >= 7 * FRAME + 5 * H_TOTAL + 70 && cyc < 7 * FRAME + 5 * H_TOTAL + 72);
    endfunction

    // Stimulus + reference model: one expected entry per clock edge.
    initial begin
        int   mp, ml, s_cw, s_ch, s_pr, s_lr;
        bit   seen, cur_fs, irqf, set_now;
        exp_t e;
        mp = 0; ml = 0; s_cw = 0; s_ch = 0; s_pr = 0; s_lr = 0;
        seen = 1'b0; irqf = 1'b0; set_now = 1'b0;
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge clk);
            rst         = reset_at(cyc);
            cell_w_m1   = 4'($urandom_range(0, 15));
            cell_h_m1   = 5'($urandom_range(0, 31));
            pix_rep_m1  = 2'($urandom_range(0, 3));
            line_rep_m1 = 2'($urandom_range(0, 3));
`ifdef SVGA_RASTER_IRQ_EN
            if (cyc % 5000 == 4999) irq_line = 10'($urandom_range(0, V_TOTAL - 1));
            set_now = (mp == 0) && (ml == int'(irq_line));
            irq_ack = ($urandom_range(0, 149) == 0) || (set_now && $urandom_range(0, 1) == 1);
`endif
            if (rst) begin
                mp = 0; ml = 0; seen = 1'b0; irqf = 1'b0;
                s_cw = 0; s_ch = 0; s_pr = 0; s_lr = 0;
                e = model_at(0, 0, 0, 0, 0, 0, 1'b0);
                e.hs = (HS_POL == 0);
                e.vs = (VS_POL == 0);
                e.blank = 1'b0;
                e.border = 1'b1;
            end else begin
                cur_fs = seen && (mp == 0) && (ml == 0);
                if (cur_fs) begin
                    s_cw = int'(cell_w_m1); s_ch = int'(cell_h_m1);
                    s_pr = int'(pix_rep_m1); s_lr = int'(line_rep_m1);
                end
                mp = mp + 1;
                if (mp == H_TOTAL) begin
                    mp = 0;
                    ml = (ml + 1) % V_TOTAL;
                end
                if (mp == 0 && ml == 0) seen = 1'b1;
                e = model_at(mp, ml, s_cw, s_ch, s_pr, s_lr, seen && mp == 0 && ml == 0);
`ifdef SVGA_RASTER_IRQ_EN
                irqf = ((mp == 0) && (ml == int'(irq_line))) || (irqf && !(irq_ack && !set_now));
`endif
                e.irq = irqf;
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Monitor: the DUT presents a full output set every cycle.
    initial begin
        exp_t act, exp_v;
        forever begin
            @(posedge clk);
            #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: empty at t=%0t, required an entry", $time);
            end else begin
                exp_v      = sb.pop_front();
                act.hs     = h_synch;
                act.vs     = v_synch;
                act.blank  = blank;
                act.border = show_border;
                act.fs     = frame_start;
                act.pc     = pixel_count;
                act.lc     = line_count;
                act.sp     = subchar_pixel;
                act.sl     = subchar_line;
                act.cc     = char_column;
                act.cl     = char_line;
                act.gx     = graph_x;
                act.gy     = graph_y;
                act.irq    = raster_irq;
                if (act !== exp_v) begin
                    errors++;
                    $display("FAIL outputs t=%0t got %h required %h (got pc %0d lc %0d, required pc %0d lc %0d)",
                             $time, act, exp_v, act.pc, act.lc, exp_v.pc, exp_v.lc);
                end
            end
            if (errors >= 100) begin
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

endmodule

// File: doc/svga_raster_timing_gen.md
Name: svga_raster_timing_gen

Overview:
Parametrised successor to the fixed 640x480 SVGA timing generator. Produces sync, blank and border signals, plus text-cell and graphics-pixel addressing counters for the video fetch pipeline. All logic runs on pixel_clock; no counter is clocked by a sync signal. Character cell size, graphics pixel/line repeat factors and the border window are run-time or parameter programmable, so one block serves every LASER310 text and graphics mode.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 1, h_synch active level
VS_POL, 1, v_synch active level
BORDER_X, 64, left/right border pixels
BORDER_Y, 48, top/bottom border lines
DECODE_DELAY, 7, fetch-pipeline lead in pixels

Ports:
pixel_clock  in  1  pixel clock
reset  in  1  asynchronous, active-high
cell_w_m1  in  4  character cell width minus 1 (7 or 15 typical)
cell_h_m1  in  5  character cell height minus 1 (11 or 23 typical)
pix_rep_m1  in  2  graphics horizontal repeat minus 1
line_rep_m1  in  2  graphics vertical repeat minus 1 (1=2x, 2=3x)
h_synch  out  1  horizontal sync, polarity HS_POL
v_synch  out  1  vertical sync, polarity VS_POL
blank  out  1  outside active area
pixel_count  out  11  0..H_TOTAL-1
line_count  out  10  0..V_TOTAL-1
show_border  out  1  border colour select
frame_start  out  1  one-cycle pulse at (0,0)
subchar_pixel  out  4  pixel within cell
subchar_line  out  5  line within cell
char_column  out  7  cell column
char_line  out  7  cell row
graph_x  out  9  graphics pixel index
graph_y  out  9  graphics line index

Behaviour:
- H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. pixel_count wraps at H_TOTAL-1. line_count increments on pixel wrap and wraps at V_TOTAL-1.
- All other outputs are registered and aligned to the same cycle as the pixel_count/line_count they describe. The implementation uses one-cycle lookahead compares.
- h_synch is active while pixel_count is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. v_synch is active while line_count is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- blank = (pixel_count>=H_ACTIVE) | (line_count>=V_ACTIVE).
- Line window: line_count in [BORDER_Y, V_ACTIVE-BORDER_Y-1].
- Fetch window: pixel_count in [BORDER_X-DECODE_DELAY, H_ACTIVE-BORDER_X-DECODE_DELAY-1].
- show_border = 0 only when pixel_count is in [BORDER_X, H_ACTIVE-BORDER_X-1] AND the line is in the line window; otherwise 1.
- Shadow config: cell_w_m1, cell_h_m1, pix_rep_m1 and line_rep_m1 are captured only on the cycle frame_start is asserted. Mid-frame changes take effect at the next frame.
- Horizontal counters (subchar_pixel, char_column, graph_x and the pixel repeat counter) clear at pixel_count==0.
  - They advance each cycle inside the fetch window.
  - subchar_pixel==cell_w_m1 causes a wrap to 0 and char_column+1.
  - graph_x increments every pix_rep_m1+1 cycles.
- Vertical counters (subchar_line, char_line, graph_y and the line repeat counter) clear at frame_start.
  - They advance at pixel_count==H_TOTAL-1 of each line inside the line window.
  - subchar_line==cell_h_m1 causes a wrap to 0 and char_line+1.
  - graph_y increments every line_rep_m1+1 lines.
- char_column, char_line, graph_x and graph_y wrap modulo their width and never saturate.
- A cell_w_m1 of 0 gives one pixel per column (legal).
- Reset, including mid-frame: all counters 0, syncs inactive, blank 0, show_border 1, frame_start 0. frame_start first asserts when the counters next return to (0,0), not on the cycle after reset release.

Optional Feature:
SVGA_RASTER_IRQ_EN: adds inputs irq_line[9:0] and irq_ack, and output raster_irq.
- raster_irq is a sticky flag, set on the cycle where pixel_count==0 and line_count==irq_line.
- irq_ack clears the flag. If set and clear happen in the same cycle, set wins.
- raster_irq resets to 0.
Without the macro, none of these ports exist and no logic is generated.

Test Plan:
- Default parameters, reset released, run 2 frames:
  - h_synch is high for exactly 96 cycles, starting at pixel 656; period 800.
  - v_synch is high for exactly 2 lines, starting at line 490; frame is 525 lines.
  - frame_start occurs once per 420000 cycles.
- cell_w_m1=15, cell_h_m1=11:
  - char_column first increments at pixel 73 and reaches 32 by line end.
  - char_line steps every 12 lines from line 48 and reaches 32.
  - show_border is 0 only over pixels 64..575 and lines 48..431.
- line_rep_m1=2, pix_rep_m1=1:
  - graph_y steps every 3 lines and ends at 128.
  - graph_x steps every 2 cycles and ends at 256 per line.
- Change cell_w_m1 from 15 to 7 at line 200: counting stays 16-wide until the next frame_start, then is 8-wide (64 columns).
- Assert reset at line 300, pixel 400, for 3 cycles: all outputs take their reset values. After release, counting restarts at (0,0) with no frame_start pulse until wrap.
- With SVGA_RASTER_IRQ_EN, irq_line=100:
  - raster_irq rises at line 100, pixel 0.
  - irq_ack asserted on line 100 of the next frame at pixel 0 leaves raster_irq at 1.
  - A later ack clears it.
